// File: rtl/mem_wait_unit_pkg.sv
// Shared definitions for the main-memory wait stage: FSM/op encodings, default widths and
// the positions of the memory strobes inside the controller's bus-control word.
package mem_wait_unit_pkg;

  localparam int unsigned DefaultDw  = 16;
  localparam int unsigned MaxLatency = 15;

  // Memory strobe positions within the 22-bit bus-control word emitted by the microcode
  localparam int unsigned BusCtlW     = 22;
  localparam int unsigned BusMemRdBit = 6;
  localparam int unsigned BusMemWrBit = 7;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } mem_state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } mem_op_e;

  function automatic logic latency_ok(input int unsigned lat);
    return (lat >= 1) && (lat <= MaxLatency);
  endfunction

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port synchronous word RAM with write enable and a registered, enable-gated read port.
// Array contents are not reset; only the read register is.
module mem_ram_sp #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register only moves on a read so writes leave the last read value intact
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_wait_unit.sv
// Fixed-latency main-memory stage: accepts controller strobes, holds wait_ high for LATENCY
// cycles, then performs the RAM access using the address/data/op latched at acceptance.
module mem_wait_unit
  import mem_wait_unit_pkg::*;
#(
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned LATENCY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          wait_,
  output logic          err_both
);

  localparam int unsigned CntW = $clog2(LATENCY + 1);

  if (!latency_ok(LATENCY)) begin : g_latency_check
    $error("mem_wait_unit: LATENCY must be within 1..15");
  end

  mem_state_e      state_d, state_q;
  logic [CntW-1:0] count_d, count_q;
  logic [AW-1:0]   addr_d, addr_q;
  logic [DW-1:0]   wdata_d, wdata_q;
  mem_op_e         op_d, op_q;
  logic            err_both_d, err_both_q;

  logic req;
  logic wait_busy;
  logic ram_we, ram_re;

  assign req = mem_rd | mem_wr;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    err_both_d = err_both_q;
    wait_busy  = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          // Raise wait_ in the request cycle so the sequencer never advances past it
          wait_busy = 1'b1;
          addr_d    = addr;
          wdata_d   = wdata;
          // A simultaneous read and write is serviced as a read
          op_d      = mem_rd ? OpRead : OpWrite;
          if (mem_rd && mem_wr) begin
            err_both_d = 1'b1;
          end
          if (LATENCY == 1) begin
            state_d = StDone;
          end else begin
            state_d = StBusy;
            count_d = CntW'(LATENCY - 1);
          end
        end
      end

      StBusy: begin
        wait_busy = 1'b1;
        count_d   = count_q - 1'b1;
        if (count_q == CntW'(1)) begin
          state_d = StDone;
        end
      end

      StDone: begin
        ram_re  = (op_q == OpRead);
        ram_we  = (op_q == OpWrite);
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= OpRead;
      err_both_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      err_both_q <= err_both_d;
    end
  end

  // Strobes may be high while reset is held; wait_ must still read low
  assign wait_    = rst_n & wait_busy;
  assign err_both = err_both_q;

  mem_ram_sp #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .rdata_o(rdata)
  );

endmodule

// File: tb/tb_mem_wait_unit.sv
// Self-checking bench for mem_wait_unit: a transaction-level model checks every cycle, plus
// directed scenarios pinned with literal expectations and a LATENCY=1 instance.
module tb_mem_wait_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [11:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        wait_, err_both;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [11:0] addr1 = '0;
  logic [15:0] wdata1 = '0;
  logic [15:0] rdata1;
  logic        wait1, err1;

  int n_checks = 0;
  int n_fail = 0;

  mem_wait_unit #(.AW(12), .DW(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .wait_(wait_), .err_both(err_both)
  );

  mem_wait_unit #(.AW(12), .DW(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_rd(rd1), .mem_wr(wr1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .wait_(wait1), .err_both(err1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model state: memory image plus the cycle window of the access in flight
  logic [15:0] mdl_mem [4096];
  bit          mdl_known [4096];
  logic [15:0] exp_rdata;
  bit          rdata_known, exp_err, e_wait, accept_both;
  int          cyc = 0, done_cyc = -1, free_at = 0;
  logic        acc_rd;
  logic [11:0] acc_addr;
  logic [15:0] acc_wdata;

  int          nw;
  logic [15:0] r0;

  function automatic logic [15:0] preload_val(input int a);
    case (a)
      'h010:   return 16'h1234;
      'h011:   return 16'h5678;
      'h020:   return 16'hAAAA;
      'h021:   return 16'h5555;
      'h030:   return 16'h0F0F;
      'h040:   return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  // Controller-style access: strobes stay up through the DONE cycle; returns at DONE negedge
  task automatic access(input logic rd, input logic wr, input logic [11:0] a,
                        input logic [11:0] a2, input logic [15:0] d,
                        output int nwait, output logic [15:0] first_rdata);
    bit done;
    nwait = 0;
    first_rdata = '0;
    done = 1'b0;
    @(posedge clk); #1;
    mem_rd = rd; mem_wr = wr; addr = a; wdata = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (i == 0) first_rdata = rdata;
      if (wait_) nwait++;
      else done = 1'b1;
      if (i == 0 && a2 != a && wait_) begin
        @(posedge clk); #1;
        addr = a2;
      end
    end
    chk("access_completes", done, 1);
  endtask

  task automatic idle1();
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          exp_rdata   = '0;
          rdata_known = 1'b1;
          exp_err     = 1'b0;
          done_cyc    = -1;
          free_at     = cyc + 1;
          chk("mon_wait_in_reset", wait_, 0);
          chk("mon_rdata_in_reset", rdata, 0);
          chk("mon_err_in_reset", err_both, 0);
        end else begin
          accept_both = 1'b0;
          if (cyc >= free_at) begin
            e_wait = mem_rd | mem_wr;
            if (e_wait) begin
              acc_rd      = mem_rd;
              acc_addr    = addr;
              acc_wdata   = wdata;
              accept_both = mem_rd & mem_wr;
              done_cyc    = cyc + LAT;
              free_at     = cyc + LAT + 1;
            end
          end else begin
            e_wait = (cyc != done_cyc);
          end
          chk("mon_wait", wait_, e_wait);
          if (rdata_known) chk("mon_rdata", rdata, exp_rdata);
          chk("mon_err_both", err_both, exp_err);
          if (accept_both) exp_err = 1'b1;
          if (cyc == done_cyc) begin
            if (acc_rd) begin
              rdata_known = mdl_known[acc_addr];
              exp_rdata   = mdl_mem[acc_addr];
            end else begin
              mdl_mem[acc_addr]   = acc_wdata;
              mdl_known[acc_addr] = 1'b1;
            end
          end
        end
        cyc++;
      end
    join_none

    // Reset with a strobe asserted: wait_ must stay low
    mem_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wait", wait_, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err_both, 0);
    chk("rst_l1_rdata", rdata1, 0);
    @(posedge clk); #1;
    mem_rd = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wait", wait_, 0);
    chk("post_rst_rdata", rdata, 0);

    for (int a = 0; a < 'h50; a++) begin
      access(1'b0, 1'b1, 12'(a), 12'(a), preload_val(a), nw, r0);
    end
    idle1();

    access(1'b0, 1'b1, 12'h005, 12'h005, 16'hBEEF, nw, r0);
    chk("wr_beef_wait_len", nw, 3);
    access(1'b1, 1'b0, 12'h005, 12'h005, 16'h0000, nw, r0);
    chk("rd_beef_wait_len", nw, 3);
    idle1();
    chk("rd_beef_data", rdata, 16'hBEEF);

    access(1'b1, 1'b0, 12'h010, 12'h010, 16'h0000, nw, r0);
    chk("b2b_first_wait_len", nw, 3);
    access(1'b1, 1'b0, 12'h011, 12'h011, 16'h0000, nw, r0);
    chk("b2b_second_wait_len", nw, 3);
    chk("b2b_first_data", r0, 16'h1234);
    idle1();
    chk("b2b_second_data", rdata, 16'h5678);
    chk("b2b_no_extra_access", wait_, 0);

    access(1'b1, 1'b0, 12'h020, 12'h021, 16'h0000, nw, r0);
    chk("addr_chg_wait_len", nw, 3);
    idle1();
    chk("addr_chg_data", rdata, 16'hAAAA);

    access(1'b1, 1'b1, 12'h030, 12'h030, 16'hFFFF, nw, r0);
    idle1();
    chk("both_rdata", rdata, 16'h0F0F);
    chk("both_err_set", err_both, 1);
    access(1'b1, 1'b0, 12'h030, 12'h030, 16'h0000, nw, r0);
    idle1();
    chk("both_ram_unchanged", rdata, 16'h0F0F);
    access(1'b0, 1'b1, 12'h031, 12'h031, 16'h1111, nw, r0);
    idle1();
    chk("both_err_sticky", err_both, 1);

    // Reset lands in the second BUSY cycle of a write
    @(posedge clk); #1;
    mem_wr = 1'b1; addr = 12'h040; wdata = 16'h9999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midwr_rst_wait", wait_, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_wr = 1'b0;
    access(1'b1, 1'b0, 12'h040, 12'h040, 16'h0000, nw, r0);
    idle1();
    chk("midwr_ram_intact", rdata, 16'h0001);
    chk("midwr_err_cleared", err_both, 0);

    for (int i = 0; i < 600; i++) begin
      int r;
      @(posedge clk); #1;
      rst_n  = ($urandom_range(0, 79) != 0);
      r      = int'($urandom_range(0, 9));
      mem_rd = (r < 2) || (r == 9);
      mem_wr = (r == 2) || (r == 3) || (r == 9);
      addr   = 12'($urandom_range(0, 'h4F));
      wdata  = 16'($urandom);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0;
    repeat (6) @(negedge clk);

    // LATENCY=1 instance: one-cycle wait_ pulse per access
    @(posedge clk); #1;
    wr1 = 1'b1; addr1 = 12'h007; wdata1 = 16'hCAFE;
    @(negedge clk);
    chk("l1_wr_wait_hi", wait1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1_wr_done_lo", wait1, 0);
    @(posedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b1;
    @(negedge clk);
    chk("l1_rd_wait_hi", wait1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l1_rd_done_lo", wait1, 0);
    @(posedge clk); #1;
    rd1 = 1'b0;
    @(negedge clk);
    chk("l1_rd_data", rdata1, 16'hCAFE);
    chk("l1_idle_lo", wait1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wait_unit.md
Name: mem_wait_unit

Overview:
- Main-memory stage that sits directly downstream of the microprogrammed controller.
- It consumes the memory read and write strobes from the controller's 22-bit bus-control word, together with the address and write data from the datapath.
- It performs a fixed-latency access to an internal word RAM and drives the controller's wait_ input, holding the microsequencer in its wait state until the access completes.
- Read data is returned registered to the datapath.

Parameters:
- AW, 12, address width; RAM depth is 2**AW words.
- DW, 16, data word width.
- LATENCY, 3, number of cycles wait_ stays high per access; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_rd  input  1  read strobe from the controller bus-control word.
- mem_wr  input  1  write strobe from the controller bus-control word.
- addr  input  AW  word address from the datapath address register.
- wdata  input  DW  write data from the accumulator/data register.
- rdata  output  DW  registered read data.
- wait_  output  1  high = access in progress; the controller must hold its state.
- err_both  output  1  sticky flag: mem_rd and mem_wr were both seen high at acceptance.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE, count=0, rdata=0, err_both=0, latched address/data/op cleared.
  - RAM contents are not cleared.
  - wait_ is 0 during reset.
- States: IDLE, BUSY, DONE. Count register width is clog2(LATENCY+1).
- IDLE:
  - Request means mem_rd or mem_wr is high.
  - With a request, wait_=1 combinationally in the same cycle, so the controller never advances on the request cycle.
  - At the rising edge: latch addr, wdata and op.
  - If LATENCY=1, go to DONE; otherwise go to BUSY with count=LATENCY-1.
  - No request: wait_=0, stay in IDLE.
- BUSY:
  - wait_=1; count decrements each edge.
  - On the edge where count=1, go to DONE.
  - Strobes and addr are ignored; only the latched copies are used.
- DONE:
  - wait_=0 for exactly one cycle.
  - At the DONE edge: a read loads rdata from RAM[latched addr]; a write stores latched wdata to RAM[latched addr].
  - Next state is IDLE unconditionally. A strobe still high during DONE is not treated as a new request.
- Timing:
  - wait_ is high for exactly LATENCY consecutive cycles, starting in the request cycle.
  - rdata is valid from the cycle after DONE and holds until the next read completes.
  - Writes never change rdata.
- Back-to-back: a strobe high in the IDLE cycle after DONE is a new access and is accepted normally. The zero-gap case, where the next microinstruction reads again, therefore works.
- Simultaneous mem_rd and mem_wr at acceptance: the access is performed as a read, the write is dropped, and err_both is set and stays set until reset.
- Reset mid-access: returns to IDLE immediately; a pending write is aborted and RAM is unmodified.
- Address wrap is implicit, since addr is exactly AW bits.
- Illegal LATENCY (0 or >15) must be caught by an elaboration-time check.

Decomposition:
- Shared package holds:
  - state encodings for IDLE/BUSY/DONE;
  - DW=16 default;
  - bit indices of mem_rd and mem_wr within the 22-bit bus-control word, so controller microcode and this block agree.
- One sub-module is natural: mem_ram_sp, a single-port synchronous RAM (AW, DW) with write enable and registered read. The FSM/counter stays in mem_wait_unit.

Test Plan:
- Reset: hold rst_n low, then release -> rdata=0, wait_=0, err_both=0, state IDLE.
- Write then read, LATENCY=3:
  - Stimulus: mem_wr=1, addr=0x005, wdata=0xBEEF held until wait_ falls; then mem_rd=1, addr=0x005.
  - Required: wait_ high exactly 3 cycles for each access; rdata=0xBEEF the cycle after the read's DONE.
- Back-to-back reads with zero idle gap:
  - Stimulus: read addr 0x010 (preloaded 0x1234) immediately followed by read addr 0x011 (preloaded 0x5678).
  - Required: two separate 3-cycle wait_ pulses; rdata=0x1234 then 0x5678; no extra access is generated from the DONE cycle.
- Address change during BUSY:
  - Stimulus: read accepted at addr 0x020 (preloaded 0xAAAA); addr switched to 0x021 during BUSY.
  - Required: rdata=0xAAAA.
- Both strobes high:
  - Stimulus: mem_rd=mem_wr=1, addr 0x030 (preloaded 0x0F0F), wdata=0xFFFF.
  - Required: rdata=0x0F0F, RAM[0x030] unchanged, err_both=1 and stays 1 after later clean accesses.
- Reset during write and LATENCY=1:
  - Reset mid-write: assert rst_n low in the second BUSY cycle of a write of 0x9999 to 0x040 (previously 0x0001); a later read of 0x040 returns 0x0001.
  - LATENCY=1 build: wait_ is a single-cycle pulse per access.
